id_ctrl_pipe: RTL and testbench

- Parametrised successor to the ID-stage main control decoder.
- Decodes the IF/ID opcode into the EX/M/WB control bundle and owns the registered ID/EX control and destination-register fields.
- Adds load-use hazard detection with bubble insertion, branch-flush squashing, a pipeline freeze input, illegal-opcode handling with an optional halt FSM, and a saturating stall counter.
- Sits between the IF/ID register and the EX stage.

---
 rtl/id_ctrl_pkg.sv | 20 ++
 rtl/id_ctrl_decode.sv | 28 ++
 rtl/id_ctrl_pipe.sv | 67 ++++++
 tb/tb_id_ctrl_pipe.sv | 119 +++++++++++
 4 files changed

// File: rtl/id_ctrl_pkg.sv
// id_ctrl_pkg: opcodes, control-bit positions, bubble values and FSM states for the ID control stage
package id_ctrl_pkg;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] NOP   = 6'b100000;
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUSRC   = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam logic [3:0] EX_BUBBLE = 4'b0000;
  localparam logic [2:0] M_BUBBLE  = 3'b000;
  localparam logic [1:0] WB_BUBBLE = 2'b00;
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
endpackage

// File: rtl/id_ctrl_decode.sv
// id_ctrl_decode: combinational opcode to control bundle, register usage and illegal flag
module id_ctrl_decode
  import id_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [3:0]          ex,
  output logic [2:0]          m,
  output logic [1:0]          wb,
  output logic                uses_rs,
  output logic                uses_rt,
  output logic                illegal
);
  logic is_r, is_lw, is_sw, is_beq, is_addi, is_nop;
  assign is_r    = opcode == OPCODE_W'(RTYPE);
  assign is_lw   = opcode == OPCODE_W'(LW);
  assign is_sw   = opcode == OPCODE_W'(SW);
  assign is_beq  = opcode == OPCODE_W'(BEQ);
  assign is_addi = opcode == OPCODE_W'(ADDI);
  assign is_nop  = opcode == OPCODE_W'(NOP);
  assign ex = is_r ? 4'b1100 : (is_lw | is_sw | is_addi) ? 4'b0001 : is_beq ? 4'b0010 : 4'b0000;
  assign m  = {is_beq, is_lw, is_sw};
  assign wb = {is_r | is_lw | is_addi, is_lw};
  assign uses_rs = is_r | is_lw | is_sw | is_beq | is_addi;
  assign uses_rt = is_r | is_sw | is_beq;
  assign illegal = ~(uses_rs | is_nop);
endmodule

// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe: ID-stage control decode with ID/EX registers, load-use bubbles, flush, freeze and illegal-opcode halt
module id_ctrl_pipe
  import id_ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 6,
  parameter int REG_W        = 5,
  parameter int CNT_W        = 16,
  parameter int ILLEGAL_HALT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                flush_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [REG_W-1:0]    rs_i,
  input  logic [REG_W-1:0]    rt_i,
  input  logic [REG_W-1:0]    rd_i,
  output logic [3:0]          ex_o,
  output logic [2:0]          m_o,
  output logic [1:0]          wb_o,
  output logic [REG_W-1:0]    dst_o,
  output logic                stall_o,
  output logic                illegal_o,
  output logic                halted_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);
  logic [3:0] d_ex;
  logic [2:0] d_m;
  logic [1:0] d_wb;
  logic uses_rs, uses_rt, d_ill, haz, bubble, count;
  state_t state;
  id_ctrl_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode (opcode_i),
    .ex     (d_ex),
    .m      (d_m),
    .wb     (d_wb),
    .uses_rs(uses_rs),
    .uses_rt(uses_rt),
    .illegal(d_ill)
  );
  // the load in EX is the only producer that cannot forward in time; r0 never hazards
  assign haz = m_o[M_MEMREAD] & (dst_o != '0) &
               ((uses_rs & (dst_o == rs_i)) | (uses_rt & (dst_o == rt_i)));
  assign halted_o = state == HALT;
  assign stall_o  = (haz & ~flush_i) | halted_o;
  assign bubble   = flush_i | halted_o | haz;
  assign count    = haz & ~flush_i & ~halted_o & ~&stall_cnt_o;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_o        <= EX_BUBBLE;
      m_o         <= M_BUBBLE;
      wb_o        <= WB_BUBBLE;
      dst_o       <= '0;
      illegal_o   <= 1'b0;
      stall_cnt_o <= '0;
      state       <= RUN;
    end else if (en_i) begin
      ex_o        <= bubble ? EX_BUBBLE : d_ex;
      m_o         <= bubble ? M_BUBBLE : d_m;
      wb_o        <= bubble ? WB_BUBBLE : d_wb;
      dst_o       <= bubble ? '0 : d_ex[EX_REGDST] ? rd_i : rt_i;
      illegal_o   <= ~bubble & d_ill;
      stall_cnt_o <= count ? stall_cnt_o + CNT_W'(1) : stall_cnt_o;
      if (~bubble & d_ill & (ILLEGAL_HALT != 0)) state <= HALT;
    end
  end
endmodule

// File: tb/tb_id_ctrl_pipe.sv
// tb_id_ctrl_pipe: directed scoreboard bench; u0 bubbles on illegal, u1 halts and has a 2-bit counter
module tb_id_ctrl_pipe;
  import id_ctrl_pkg::*;
  localparam logic [5:0] ILL = 6'b111111;
  logic clk = 0, rst_n = 0, en = 1, fl = 0;
  logic [5:0] op = NOP;
  logic [4:0] rs = 0, rt = 0, rd = 0;
  logic [3:0] ex0, ex1;
  logic [2:0] m0, m1;
  logic [1:0] wb0, wb1, cnt1;
  logic [4:0] dst0, dst1;
  logic st0, st1, il0, il1, h0, h1;
  logic [15:0] cnt0;
  typedef struct packed {
    logic [3:0] ex; logic [2:0] m; logic [1:0] wb; logic [4:0] dst;
    logic ill; logic h0; logic [15:0] cnt; logic h1; logic [1:0] c1;
  } obs_t;
  obs_t q[$];
  int compared = 0, mismatched = 0;

  id_ctrl_pipe u0 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .flush_i(fl), .opcode_i(op), .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .ex_o(ex0), .m_o(m0), .wb_o(wb0), .dst_o(dst0), .stall_o(st0), .illegal_o(il0), .halted_o(h0),
    .stall_cnt_o(cnt0)
  );
  id_ctrl_pipe #(.CNT_W(2), .ILLEGAL_HALT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .flush_i(fl), .opcode_i(op), .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .ex_o(ex1), .m_o(m1), .wb_o(wb1), .dst_o(dst1), .stall_o(st1), .illegal_o(il1), .halted_o(h1),
    .stall_cnt_o(cnt1)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb,
                              input logic [4:0] dst, input logic ill, input logic [15:0] cnt,
                              input logic hh, input logic [1:0] c1);
    return {ex, m, wb, dst, ill, 1'b0, cnt, hh, c1};
  endfunction

  function automatic obs_t cur();
    return {ex0, m0, wb0, dst0, il0, h0, cnt0, h1, cnt1};
  endfunction

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic e_n, input logic f, input logic exp_st, input obs_t e);
    obs_t got, want;
    @(negedge clk);
    op = o; rs = s; rt = t; rd = d; en = e_n; fl = f;
    #1;
    check({tag, "_stall"}, 64'(st0), 64'(exp_st));
    q.push_back(e);
    @(posedge clk);
    #1;
    got = cur();
    want = q.pop_front();
    check(tag, 64'(got), 64'(want));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'(cur()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    check("reset_stall", 64'({st0, st1, il1}), 64'(0));
    @(negedge clk);
    rst_n = 1;
    step("rtype",      RTYPE, 1, 2, 3, 1, 0, 0, mk(4'b1100, 3'b000, 2'b10, 3, 0, 0, 0, 0));
    step("lw_r5",      LW,    1, 5, 9, 1, 0, 0, mk(4'b0001, 3'b010, 2'b11, 5, 0, 0, 0, 0));
    step("use_rs_haz", RTYPE, 5, 2, 6, 1, 0, 1, mk(0, 0, 0, 0, 0, 1, 0, 1));
    step("use_rs_iss", RTYPE, 5, 2, 6, 1, 0, 0, mk(4'b1100, 3'b000, 2'b10, 6, 0, 1, 0, 1));
    step("lw_r0",      LW,    0, 0, 0, 1, 0, 0, mk(4'b0001, 3'b010, 2'b11, 0, 0, 1, 0, 1));
    step("use_r0",     RTYPE, 0, 0, 7, 1, 0, 0, mk(4'b1100, 3'b000, 2'b10, 7, 0, 1, 0, 1));
    step("lw_r5b",     LW,    1, 5, 0, 1, 0, 0, mk(4'b0001, 3'b010, 2'b11, 5, 0, 1, 0, 1));
    step("sw_rt_haz",  SW,    1, 5, 0, 1, 0, 1, mk(0, 0, 0, 0, 0, 2, 0, 2));
    step("sw_iss",     SW,    1, 5, 0, 1, 0, 0, mk(4'b0001, 3'b001, 2'b00, 5, 0, 2, 0, 2));
    step("lw_r5c",     LW,    1, 5, 0, 1, 0, 0, mk(4'b0001, 3'b010, 2'b11, 5, 0, 2, 0, 2));
    step("addi_dest",  ADDI,  2, 5, 0, 1, 0, 0, mk(4'b0001, 3'b000, 2'b10, 5, 0, 2, 0, 2));
    step("lw_r5d",     LW,    1, 5, 0, 1, 0, 0, mk(4'b0001, 3'b010, 2'b11, 5, 0, 2, 0, 2));
    step("haz_flush",  BEQ,   5, 5, 0, 1, 1, 0, mk(0, 0, 0, 0, 0, 2, 0, 2));
    step("lw_r4",      LW,    1, 4, 0, 1, 0, 0, mk(4'b0001, 3'b010, 2'b11, 4, 0, 2, 0, 2));
    for (int i = 0; i < 3; i++)
      step("freeze",   BEQ,   4, 1, 0, 0, 0, 1, mk(4'b0001, 3'b010, 2'b11, 4, 0, 2, 0, 2));
    step("thaw_haz",   BEQ,   4, 1, 0, 1, 0, 1, mk(0, 0, 0, 0, 0, 3, 0, 3));
    step("beq_iss",    BEQ,   4, 1, 0, 1, 0, 0, mk(4'b0010, 3'b100, 2'b00, 1, 0, 3, 0, 3));
    step("lw_r6",      LW,    0, 6, 0, 1, 0, 0, mk(4'b0001, 3'b010, 2'b11, 6, 0, 3, 0, 3));
    step("rt_haz_sat", RTYPE, 1, 6, 2, 1, 0, 1, mk(0, 0, 0, 0, 0, 4, 0, 3));
    step("rtype_iss",  RTYPE, 1, 6, 2, 1, 0, 0, mk(4'b1100, 3'b000, 2'b10, 2, 0, 4, 0, 3));
    step("illegal",    ILL,   0, 0, 0, 1, 0, 0, mk(0, 0, 0, 0, 1, 4, 1, 3));
    check("halt_stall", 64'(st1), 64'(1));
    step("post_ill",   RTYPE, 1, 2, 3, 1, 0, 0, mk(4'b1100, 3'b000, 2'b10, 3, 0, 4, 1, 3));
    check("halt_bubble", 64'({ex1, m1, wb1, dst1, il1, st1}), 64'(1));
    step("lw_r5e",     LW,    1, 5, 0, 1, 0, 0, mk(4'b0001, 3'b010, 2'b11, 5, 0, 4, 1, 3));
    check("halt_hold", 64'({ex1, m1, wb1, dst1, st1}), 64'(1));
    @(negedge clk);
    op = RTYPE; rs = 5; rt = 2; rd = 6;
    #1;
    check("pre_rst_stall", 64'(st0), 64'(1));
    rst_n = 0;
    #1;
    check("async_rst", 64'(cur()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    check("async_rst_stall", 64'({st0, st1}), 64'(0));
    if (q.size() != 0) check("queue_drained", 64'(q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
